// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BURST_MAX = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requesting index at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any_req
);

  localparam int GW = $clog2(NUM_REQ);

  logic [GW:0] idx;

  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = '0;
    // Scan from the farthest offset down so the requester nearest rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (GW + 1)'(k);
      if (idx >= (GW + 1)'(NUM_REQ)) begin
        idx = idx - (GW + 1)'(NUM_REQ);
      end
      if (req[idx[GW-1:0]]) begin
        grant = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-granting write arbiter from NUM_REQ producers into one shared FIFO.
// Define FIFO_WR_ARB_STATS_EN to build the per-producer accepted-beat counters.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic                            fifo_wr_cs,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [NUM_REQ*32-1:0]           stat_beats
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  state_t        state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] beat_cnt_inc;
  logic [GW-1:0] arb_idx;
  logic          arb_any;
  logic          beat_xfer;
  logic          burst_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_idx),
    .any_req (arb_any)
  );

  assign beat_cnt_inc = beat_cnt_q + CW'(1);
  assign beat_xfer    = (state_q == ST_XFER) && req_valid[grant_id_q] && !fifo_full;
  // A burst ends on the packet's last beat or when the grant's beat budget is spent.
  assign burst_end    = beat_xfer && (req_last[grant_id_q] || (beat_cnt_inc == CW'(BURST_MAX)));

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_id_d = arb_idx;
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat_xfer) begin
          beat_cnt_d = beat_cnt_inc;
          if (burst_end) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        req_ready[i] = beat_xfer;
        fifo_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_wr_en = beat_xfer;
  assign fifo_wr_cs = beat_xfer;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q == ST_XFER);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (beat_xfer) begin
      stat_d[grant_id_q] = stat_q[grant_id_q] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_beats = stat_q;
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: scripted producers, write log, hand-computed expectations.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int BM = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic             fifo_wr_cs;
  logic [DW-1:0]    fifo_data;
  logic [1:0]       grant_id;
  logic             busy;
  logic [NR*32-1:0] stat_beats;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wr_cs (fifo_wr_cs),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .stat_beats (stat_beats)
  );

  int n_cmp = 0;
  int n_err = 0;

  int total[NR];
  int sent[NR];
  int plen[NR];
  logic [NR-1:0] rdy_smp;
  int cyc;
  int full_lo, full_hi, gap_lo, gap_hi, gap_prod;

  int          n_wr;
  int          wr_gid[64];
  logic [DW-1:0] wr_dat[64];
  int          wr_cyc[64];
  logic        tr_wr[64];
  logic        tr_rdy[64];
  logic        tr_busy[64];

  function automatic logic [DW-1:0] beat_val(int p, int s);
    return DW'(p * 256 + s);
  endfunction

  task automatic prod_clear();
    for (int i = 0; i < NR; i++) begin
      total[i] = 0;
      sent[i]  = 0;
      plen[i]  = 1;
    end
    rdy_smp  = '0;
    full_lo  = 0;
    full_hi  = 0;
    gap_lo   = 0;
    gap_hi   = 0;
    gap_prod = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (sent[i] < total[i]) && !(i == gap_prod && cyc >= gap_lo && cyc < gap_hi);
      req_data[i*DW +: DW] = beat_val(i, sent[i]);
      req_last[i] = (((sent[i] + 1) % plen[i]) == 0);
    end
    fifo_full = (cyc >= full_lo) && (cyc < full_hi);
  endtask

  task automatic run_cycles(int n);
    logic [NR-1:0] exp_rdy;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      for (int i = 0; i < NR; i++) if (rdy_smp[i]) sent[i]++;
      #1;
      drive();
      @(negedge clk);
      rdy_smp = req_ready;
      if (cyc < 64) begin
        tr_wr[cyc]   = fifo_wr_en;
        tr_rdy[cyc]  = |req_ready;
        tr_busy[cyc] = busy;
      end
      if (fifo_wr_en === 1'b1 && n_wr < 64) begin
        wr_gid[n_wr] = int'(grant_id);
        wr_dat[n_wr] = fifo_data;
        wr_cyc[n_wr] = cyc;
        n_wr++;
      end
      n_cmp++;
      if (fifo_wr_cs !== fifo_wr_en) begin
        n_err++;
        $display("FAIL cs_eq cyc %0d: wr_cs %b wr_en %b", cyc, fifo_wr_cs, fifo_wr_en);
      end
      exp_rdy = fifo_wr_en ? (NR'(1) << grant_id) : '0;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL ready_onehot cyc %0d: got %b want %b", cyc, req_ready, exp_rdy);
      end
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    prod_clear();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0;
    cyc  = 0;
    for (int c = 0; c < 64; c++) begin
      tr_wr[c]   = 1'b0;
      tr_rdy[c]  = 1'b0;
      tr_busy[c] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    prod_clear();
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({fifo_wr_en, fifo_wr_cs, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: wr_en/cs/busy %b%b%b want 000", fifo_wr_en, fifo_wr_cs, busy);
    end
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL reset_grant: got %0d want 0", grant_id);
    end
    n_cmp++;
    if (stat_beats !== '0) begin
      n_err++;
      $display("FAIL reset_stats: got %h want 0", stat_beats);
    end
    do_reset();
    run_cycles(3);
    n_cmp++;
    if (n_wr !== 0 || tr_busy[2] !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: writes %0d busy %b want 0 0", n_wr, tr_busy[2]);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    total[0] = 3;
    plen[0]  = 3;
    run_cycles(6);
    n_cmp++;
    if (n_wr !== 3) begin
      n_err++;
      $display("FAIL single_count: got %0d want 3", n_wr);
    end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (wr_gid[j] !== 0 || wr_dat[j] !== beat_val(0, j) || wr_cyc[j] !== 1 + j) begin
        n_err++;
        $display("FAIL single_beat%0d: gid %0d data %h cyc %0d want 0 %h %0d",
                 j, wr_gid[j], wr_dat[j], wr_cyc[j], beat_val(0, j), 1 + j);
      end
    end
    n_cmp++;
    if (tr_busy[4] !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: busy %b want 0", tr_busy[4]);
    end
    // Pointer moved to 1: with 0 and 1 both requesting, 1 must win first.
    n_wr = 0;
    total[0] = 4;
    plen[0]  = 1;
    total[1] = 1;
    plen[1]  = 1;
    run_cycles(8);
    n_cmp++;
    if (n_wr !== 2 || wr_gid[0] !== 1 || wr_gid[1] !== 0 || wr_dat[1] !== beat_val(0, 3)) begin
      n_err++;
      $display("FAIL rr_ptr_next: n %0d gids %0d,%0d data %h want 2 1,0 %h",
               n_wr, wr_gid[0], wr_gid[1], wr_dat[1], beat_val(0, 3));
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NR; i++) begin
      total[i] = 4;
      plen[i]  = 2;
    end
    run_cycles(30);
    n_cmp++;
    if (n_wr !== 16) begin
      n_err++;
      $display("FAIL rr_count: got %0d want 16", n_wr);
    end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (wr_gid[j] !== (j / 2) % 4 || wr_dat[j] !== beat_val((j / 2) % 4, (j / 8) * 2 + j % 2)) begin
        n_err++;
        $display("FAIL rr_beat%0d: gid %0d data %h want %0d %h", j, wr_gid[j], wr_dat[j],
                 (j / 2) % 4, beat_val((j / 2) % 4, (j / 8) * 2 + j % 2));
      end
    end
    for (int j = 2; j < 16; j += 2) begin
      n_cmp++;
      if (wr_cyc[j] - wr_cyc[j-1] !== 2 || wr_cyc[j-1] - wr_cyc[j-2] !== 1) begin
        n_err++;
        $display("FAIL rr_bubble%0d: gaps %0d,%0d want 1,2", j,
                 wr_cyc[j-1] - wr_cyc[j-2], wr_cyc[j] - wr_cyc[j-1]);
      end
    end
  endtask

  task automatic test_truncate();
    int eg, es;
    do_reset();
    total[0] = 2;  plen[0] = 2;
    total[2] = 12; plen[2] = 12;
    total[3] = 2;  plen[3] = 2;
    run_cycles(30);
    n_cmp++;
    if (n_wr !== 16) begin
      n_err++;
      $display("FAIL trunc_count: got %0d want 16", n_wr);
    end
    for (int j = 0; j < 16; j++) begin
      eg = (j < 2) ? 0 : (j < 10) ? 2 : (j < 12) ? 3 : 2;
      es = (j < 2) ? j : (j < 10) ? j - 2 : (j < 12) ? j - 10 : j - 4;
      n_cmp++;
      if (wr_gid[j] !== eg || wr_dat[j] !== beat_val(eg, es)) begin
        n_err++;
        $display("FAIL trunc_beat%0d: gid %0d data %h want %0d %h", j, wr_gid[j], wr_dat[j],
                 eg, beat_val(eg, es));
      end
    end
    n_cmp++;
    if (wr_cyc[10] - wr_cyc[9] !== 2) begin
      n_err++;
      $display("FAIL trunc_release: gap %0d want 2", wr_cyc[10] - wr_cyc[9]);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    total[1] = 6;
    plen[1]  = 6;
    full_lo  = 3;
    full_hi  = 8;
    run_cycles(16);
    for (int c = 3; c < 8; c++) begin
      n_cmp++;
      if (tr_wr[c] !== 1'b0 || tr_rdy[c] !== 1'b0 || tr_busy[c] !== 1'b1) begin
        n_err++;
        $display("FAIL full_stall cyc %0d: wr %b rdy %b busy %b want 0 0 1", c, tr_wr[c],
                 tr_rdy[c], tr_busy[c]);
      end
    end
    n_cmp++;
    if (n_wr !== 6 || wr_cyc[2] !== 8) begin
      n_err++;
      $display("FAIL full_resume: n %0d cyc %0d want 6 8", n_wr, wr_cyc[2]);
    end
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (wr_gid[j] !== 1 || wr_dat[j] !== beat_val(1, j)) begin
        n_err++;
        $display("FAIL full_beat%0d: gid %0d data %h want 1 %h", j, wr_gid[j], wr_dat[j],
                 beat_val(1, j));
      end
    end
  endtask

  task automatic test_valid_stall();
    int ec[4];
    ec = '{1, 5, 6, 7};
    do_reset();
    total[3] = 4;
    plen[3]  = 4;
    gap_prod = 3;
    gap_lo   = 2;
    gap_hi   = 5;
    run_cycles(12);
    n_cmp++;
    if (n_wr !== 4 || tr_busy[3] !== 1'b1) begin
      n_err++;
      $display("FAIL vstall_hold: n %0d busy %b want 4 1", n_wr, tr_busy[3]);
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (wr_gid[j] !== 3 || wr_dat[j] !== beat_val(3, j) || wr_cyc[j] !== ec[j]) begin
        n_err++;
        $display("FAIL vstall_beat%0d: gid %0d data %h cyc %0d want 3 %h %0d", j, wr_gid[j],
                 wr_dat[j], wr_cyc[j], beat_val(3, j), ec[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    total[2] = 5;
    plen[2]  = 5;
    run_cycles(3);
    n_cmp++;
    if (n_wr !== 2 || tr_wr[2] !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: n %0d wr %b want 2 1", n_wr, tr_wr[2]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_wr_en, fifo_wr_cs, busy} !== 3'b000 || req_ready !== '0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL rmid_abort: en/cs/busy %b%b%b rdy %b gid %0d want 000 0000 0",
               fifo_wr_en, fifo_wr_cs, busy, req_ready, grant_id);
    end
    do_reset();
    total[0] = 1; plen[0] = 1;
    total[2] = 1; plen[2] = 1;
    run_cycles(8);
    n_cmp++;
    if (n_wr !== 2 || wr_gid[0] !== 0 || wr_gid[1] !== 2) begin
      n_err++;
      $display("FAIL rmid_restart: n %0d gids %0d,%0d want 2 0,2", n_wr, wr_gid[0], wr_gid[1]);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_st[NR];
`ifdef FIFO_WR_ARB_STATS_EN
    exp_st = '{32'd0, 32'd10, 32'd0, 32'd6};
`else
    exp_st = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    do_reset();
    total[1] = 10; plen[1] = 10;
    total[3] = 6;  plen[3] = 6;
    run_cycles(40);
    n_cmp++;
    if (n_wr !== 16) begin
      n_err++;
      $display("FAIL stats_writes: got %0d want 16", n_wr);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (stat_beats[i*32 +: 32] !== exp_st[i]) begin
        n_err++;
        $display("FAIL stats_cnt%0d: got %0d want %0d", i, stat_beats[i*32 +: 32], exp_st[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    n_wr      = 0;
    cyc       = 0;
    prod_clear();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_truncate();
    test_fifo_full();
    test_valid_stall();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
